datapath: RTL and testbench

//  Execution datapath driven by the processor control unit's per-cycle control word.

---
 rtl/datapath_if.sv | 39 +++
 rtl/datapath.sv | 93 +++++++++
 tb/tb_datapath.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_if.sv
// Control-word and status bundle between the controller and the execution datapath.
// master = controller side, slave = datapath side.
interface datapath_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RF_AW  = 4
);
  logic [ADDR_W-1:0] d_addr;
  logic              d_wr;
  logic              rf_s;
  logic [RF_AW-1:0]  rf_w_addr;
  logic              rf_w_wr;
  logic [RF_AW-1:0]  rf_ra_addr;
  logic              rf_ra_rd;
  logic [RF_AW-1:0]  rf_rb_addr;
  logic              rf_rb_rd;
  logic [2:0]        alu_s0;
  logic              init_wr;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] mem_q;
  logic              flag_z;
  logic              flag_c;

  modport master (
    output d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr, rf_ra_addr, rf_ra_rd,
           rf_rb_addr, rf_rb_rd, alu_s0, init_wr, init_addr, init_data,
    input  ra_data, rb_data, alu_out, mem_q, flag_z, flag_c
  );

  modport slave (
    input  d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr, rf_ra_addr, rf_ra_rd,
           rf_rb_addr, rf_rb_rd, alu_s0, init_wr, init_addr, init_data,
    output ra_data, rb_data, alu_out, mem_q, flag_z, flag_c
  );
endinterface

// File: rtl/datapath.sv
// Execution datapath: 16-entry register file, synchronous data memory with preload,
// 8-op ALU, write-back mux and registered Z/C flags.
module datapath #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RF_AW  = 4
) (
  input  logic       clock,
  input  logic       reset,
  datapath_if.slave  bus
);
  localparam int unsigned NREG = 2 ** RF_AW;
  localparam int unsigned NMEM = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] mem  [NMEM];
  logic [DATA_W-1:0] mem_q;
  logic              flag_z;
  logic              flag_c;

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] wb;

  assign a = bus.rf_ra_rd ? regs[bus.rf_ra_addr] : '0;
  assign b = bus.rf_rb_rd ? regs[bus.rf_rb_addr] : '0;

  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.alu_s0)
      3'd0: alu_res = a;
      3'd1: begin
        sum       = {1'b0, a} + {1'b0, b};
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      3'd2: begin
        alu_res   = a - b;
        alu_carry = (a < b);
      end
      3'd3: alu_res = a & b;
      3'd4: alu_res = a | b;
      3'd5: alu_res = a ^ b;
      3'd6: alu_res = ~a;
      default: begin
        sum       = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
    endcase
  end

  assign wb = bus.rf_s ? mem_q : alu_res;

  // Register file, read register and flags; reads see pre-edge contents (no bypass).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      mem_q  <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      mem_q <= mem[bus.d_addr];
      if (bus.rf_w_wr) begin
        regs[bus.rf_w_addr] <= wb;
        if (!bus.rf_s) begin
          flag_z <= (alu_res == '0);
          flag_c <= alu_carry;
        end
      end
    end
  end

  // Memory contents survive reset, but no write lands while reset is asserted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (bus.init_wr)   mem[bus.init_addr] <= bus.init_data;
      else if (bus.d_wr) mem[bus.d_addr]    <= a;
    end
  end

  assign bus.ra_data = a;
  assign bus.rb_data = b;
  assign bus.alu_out = alu_res;
  assign bus.mem_q   = mem_q;
  assign bus.flag_z  = flag_z;
  assign bus.flag_c  = flag_c;
endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: behavioural model compared every cycle, directed scenarios
// with literal expectations, then randomized control words.
module tb_datapath;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  datapath_if #(.DATA_W(16), .ADDR_W(8), .RF_AW(4)) bus ();
  datapath #(.DATA_W(16), .ADDR_W(8), .RF_AW(4)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  logic [15:0] m_r [16];
  logic [15:0] m_m [256];
  logic [15:0] m_q;
  logic        m_z;
  logic        m_c;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] m_ra();
    return bus.rf_ra_rd ? m_r[bus.rf_ra_addr] : 16'h0000;
  endfunction
  function automatic logic [15:0] m_rb();
    return bus.rf_rb_rd ? m_r[bus.rf_rb_addr] : 16'h0000;
  endfunction

  // Returns {carry, result} from plain unsigned integer arithmetic.
  function automatic logic [16:0] m_alu();
    int unsigned x = m_ra();
    int unsigned y = m_rb();
    int unsigned r = 0;
    bit c = 1'b0;
    case (bus.alu_s0)
      3'd0: r = x;
      3'd1: begin r = x + y; c = (r > 65535); end
      3'd2: begin r = x + 65536 - y; c = (x < y); end
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: r = 65535 - x;
      default: begin r = x + 1; c = (r > 65535); end
    endcase
    r = r % 65536;
    return {c, r[15:0]};
  endfunction

  function automatic void model_update();
    logic [16:0] al = m_alu();
    logic [15:0] wbv = bus.rf_s ? m_q : al[15:0];
    logic [15:0] av = m_ra();
    if (reset) begin
      for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
      m_q = 16'h0000;
      m_z = 1'b0;
      m_c = 1'b0;
    end else begin
      m_q = m_m[bus.d_addr];
      if (bus.init_wr)   m_m[bus.init_addr] = bus.init_data;
      else if (bus.d_wr) m_m[bus.d_addr] = av;
      if (bus.rf_w_wr) begin
        m_r[bus.rf_w_addr] = wbv;
        if (!bus.rf_s) begin
          m_z = (al[15:0] == 16'h0000);
          m_c = al[16];
        end
      end
    end
  endfunction

  always @(negedge clock) begin
    if (cmp_on) begin
      logic [16:0] al;
      al = m_alu();
      check("ra_data", bus.ra_data, m_ra());
      check("rb_data", bus.rb_data, m_rb());
      check("alu_out", bus.alu_out, al[15:0]);
      check("mem_q", bus.mem_q, m_q);
      check("flag_z", {15'd0, bus.flag_z}, {15'd0, m_z});
      check("flag_c", {15'd0, bus.flag_c}, {15'd0, m_c});
    end
  end

  task automatic idle();
    reset          = 1'b0;
    bus.d_addr     = '0;
    bus.d_wr       = 1'b0;
    bus.rf_s       = 1'b0;
    bus.rf_w_addr  = '0;
    bus.rf_w_wr    = 1'b0;
    bus.rf_ra_addr = '0;
    bus.rf_ra_rd   = 1'b0;
    bus.rf_rb_addr = '0;
    bus.rf_rb_rd   = 1'b0;
    bus.alu_s0     = '0;
    bus.init_wr    = 1'b0;
    bus.init_addr  = '0;
    bus.init_data  = '0;
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic read_a(input logic [3:0] r);
    idle();
    bus.rf_ra_addr = r;
    bus.rf_ra_rd   = 1'b1;
    #1;
  endtask

  task automatic load_reg(input logic [3:0] r, input logic [7:0] ad, input logic [15:0] v);
    idle(); bus.init_wr = 1'b1; bus.init_addr = ad; bus.init_data = v; step();
    idle(); bus.d_addr = ad; step();
    idle(); bus.rf_s = 1'b1; bus.rf_w_addr = r; bus.rf_w_wr = 1'b1; step();
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] w);
    idle();
    bus.alu_s0 = op;
    bus.rf_ra_addr = ra; bus.rf_ra_rd = 1'b1;
    bus.rf_rb_addr = rb; bus.rf_rb_rd = 1'b1;
    bus.rf_w_addr = w;  bus.rf_w_wr = 1'b1;
    step();
  endtask

  task automatic flags(input string name, input logic z, input logic c);
    check({name, "_z"}, {15'd0, bus.flag_z}, {15'd0, z});
    check({name, "_c"}, {15'd0, bus.flag_c}, {15'd0, c});
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step(); step();
    for (int i = 0; i < 256; i++) begin
      idle();
      bus.init_wr = 1'b1; bus.init_addr = 8'(i); bus.init_data = 16'($urandom);
      step();
    end
    idle(); reset = 1'b1; step();
    idle();
    cmp_on = 1'b1;
    check("reset_mem_q", bus.mem_q, 16'h0000);
    flags("reset", 1'b0, 1'b0);

    load_reg(4'd3, 8'h10, 16'h1234);
    read_a(4'd3);
    check("load_r3", bus.ra_data, 16'h1234);
    flags("load", 1'b0, 1'b0);

    load_reg(4'd1, 8'h11, 16'h0005);
    load_reg(4'd2, 8'h12, 16'h0007);
    load_reg(4'd7, 8'h13, 16'hFFFF);

    alu_op(3'd1, 4'd1, 4'd2, 4'd4);
    read_a(4'd4); check("add", bus.ra_data, 16'h000C); flags("add", 1'b0, 1'b0);
    alu_op(3'd2, 4'd1, 4'd2, 4'd5);
    read_a(4'd5); check("sub", bus.ra_data, 16'hFFFE); flags("sub", 1'b0, 1'b1);
    alu_op(3'd2, 4'd1, 4'd1, 4'd6);
    read_a(4'd6); check("sub_self", bus.ra_data, 16'h0000); flags("sub_self", 1'b1, 1'b0);
    alu_op(3'd7, 4'd7, 4'd0, 4'd8);
    read_a(4'd8); check("inc_wrap", bus.ra_data, 16'h0000); flags("inc_wrap", 1'b1, 1'b1);

    idle(); bus.init_wr = 1'b1; bus.init_addr = 8'h20; bus.init_data = 16'hAAAA; step();
    idle(); bus.rf_ra_addr = 4'd4; bus.rf_ra_rd = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 8'h20;
    step();
    check("rdw_old", bus.mem_q, 16'hAAAA);
    idle(); bus.d_addr = 8'h20; step();
    check("store", bus.mem_q, 16'h000C);

    idle(); bus.rf_ra_addr = 4'd4; bus.rf_ra_rd = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 8'h30;
    bus.init_wr = 1'b1; bus.init_addr = 8'h30; bus.init_data = 16'h5555;
    step();
    idle(); bus.d_addr = 8'h30; step();
    check("init_prio", bus.mem_q, 16'h5555);

    idle(); bus.rf_ra_addr = 4'd4; #1;
    check("ra_disabled", bus.ra_data, 16'h0000);

    idle(); bus.rf_ra_addr = 4'd4; bus.rf_ra_rd = 1'b1;
    bus.rf_rb_addr = 4'd2; bus.rf_rb_rd = 1'b1;
    bus.rf_w_addr = 4'd2; bus.rf_w_wr = 1'b1; bus.alu_s0 = 3'd0;
    #1;
    check("nobypass_old", bus.rb_data, 16'h0007);
    step();
    idle(); bus.rf_rb_addr = 4'd2; bus.rf_rb_rd = 1'b1; #1;
    check("nobypass_new", bus.rb_data, 16'h000C);

    idle(); reset = 1'b1; bus.rf_w_wr = 1'b1; bus.rf_w_addr = 4'd1;
    bus.rf_ra_addr = 4'd4; bus.rf_ra_rd = 1'b1; step();
    read_a(4'd1);
    check("rst_r1", bus.ra_data, 16'h0000);
    check("rst_mem_q", bus.mem_q, 16'h0000);
    flags("rst", 1'b0, 1'b0);
    idle(); bus.d_addr = 8'h10; step();
    check("rst_mem_kept", bus.mem_q, 16'h1234);

    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(63) == 0);
      bus.d_addr     = 8'($urandom);
      bus.d_wr       = 1'($urandom);
      bus.rf_s       = 1'($urandom);
      bus.rf_w_addr  = 4'($urandom);
      bus.rf_w_wr    = 1'($urandom);
      bus.rf_ra_addr = 4'($urandom);
      bus.rf_ra_rd   = ($urandom_range(7) != 0);
      bus.rf_rb_addr = 4'($urandom);
      bus.rf_rb_rd   = ($urandom_range(7) != 0);
      bus.alu_s0     = 3'($urandom);
      bus.init_wr    = ($urandom_range(7) == 0);
      bus.init_addr  = 8'($urandom);
      bus.init_data  = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
      step();
    end

    idle(); step();
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
